// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM state encodings and register-address constants for pipe_hazard_ctrl.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, INJECT = 2'd2} state_t;
  localparam logic [3:0] REG_ZERO = 4'h0;
  localparam logic [3:0] REG_LINK = 4'hF;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline-to-hazard-controller bundle.
// Hazard sources: ex_mem_re, ex_we, ex_dst_addr, id_p*_addr/used, branch_taken, mem_busy, ex_send, tx_full, irq_req.
// Controls: pc_hold, stall_*, flush_*, ex_mem_bubble, store_current, irq_ack. master = pipeline, slave = controller.
interface pipe_hazard_ctrl_if;
  logic       ex_mem_re;
  logic       ex_we;
  logic [3:0] ex_dst_addr;
  logic [3:0] id_p0_addr;
  logic [3:0] id_p1_addr;
  logic       id_p0_used;
  logic       id_p1_used;
  logic       branch_taken;
  logic       mem_busy;
  logic       ex_send;
  logic       tx_full;
  logic       irq_req;
  logic       pc_hold;
  logic       stall_if_id;
  logic       stall_id_ex;
  logic       stall_ex_mem;
  logic       flush_if_id;
  logic       flush_id_ex;
  logic       ex_mem_bubble;
  logic       store_current;
  logic       irq_ack;
  modport master (
    output ex_mem_re, ex_we, ex_dst_addr, id_p0_addr, id_p1_addr, id_p0_used, id_p1_used,
           branch_taken, mem_busy, ex_send, tx_full, irq_req,
    input  pc_hold, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex,
           ex_mem_bubble, store_current, irq_ack
  );
  modport slave (
    input  ex_mem_re, ex_we, ex_dst_addr, id_p0_addr, id_p1_addr, id_p0_used, id_p1_used,
           branch_taken, mem_busy, ex_send, tx_full, irq_req,
    output pc_hold, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex,
           ex_mem_bubble, store_current, irq_ack
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use and SPART transmit-wait detection.
// Inputs: ID/EX load/write/destination, decode sources and usage, ex_send, tx_full. Outputs: load_use, tx_wait.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_mem_re,
  input  logic       ex_we,
  input  logic [3:0] ex_dst_addr,
  input  logic [3:0] id_p0_addr,
  input  logic [3:0] id_p1_addr,
  input  logic       id_p0_used,
  input  logic       id_p1_used,
  input  logic       ex_send,
  input  logic       tx_full,
  output logic       load_use,
  output logic       tx_wait
);
  // R0 reads as zero, so a load targeting it never feeds a consumer
  assign load_use = ex_mem_re & ex_we & (ex_dst_addr != REG_ZERO) &
                    ((id_p0_used & (id_p0_addr == ex_dst_addr)) |
                     (id_p1_used & (id_p1_addr == ex_dst_addr)));
  assign tx_wait  = ex_send & tx_full;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/interrupt-injection sequencer for the 5-stage pipeline.
// Ports: clk, rst (sync, active-low), bus (pipe_hazard_ctrl_if.slave), state_o (debug FSM state),
// stall_cnt/flush_cnt (performance counters, present only with PIPE_PERF_CNT_EN defined, else tied to 0).
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.slave   bus,
  output logic [1:0]          state_o,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);
  localparam logic [2:0] LAST = 3'(DRAIN_CYCLES - 1);
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       ack_q, ack_d;
  logic       load_use, tx_wait;
  logic       ph, sif, sie, sem, fif, fie, bub, sc, ack;
  hazard_detect u_hd (
    .ex_mem_re   (bus.ex_mem_re),
    .ex_we       (bus.ex_we),
    .ex_dst_addr (bus.ex_dst_addr),
    .id_p0_addr  (bus.id_p0_addr),
    .id_p1_addr  (bus.id_p1_addr),
    .id_p0_used  (bus.id_p0_used),
    .id_p1_used  (bus.id_p1_used),
    .ex_send     (bus.ex_send),
    .tx_full     (bus.tx_full),
    .load_use    (load_use),
    .tx_wait     (tx_wait)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    {ph, sif, sie, sem, fif, fie, bub, sc, ack} = '0;
    if (bus.mem_busy) begin
      {ph, sif, sie, sem} = '1;
    end else if (tx_wait) begin
      {ph, sif, sie, bub} = '1;
    end else if (bus.branch_taken) begin
      // an interrupt in flight restarts draining so the saved PC is the branch target
      {fif, fie} = '1;
      if (state_q != RUN) begin
        state_d = DRAIN;
        cnt_d   = '0;
      end
    end else if (load_use) begin
      {ph, sif, fie} = '1;
    end else if (state_q == RUN) begin
      // ack_q blocks re-acceptance in the cycle right after an acknowledge
      if (bus.irq_req && !ack_q) begin
        {ph, fif} = '1;
        state_d   = DRAIN;
        cnt_d     = '0;
      end
    end else if (state_q == DRAIN) begin
      if (!bus.irq_req) begin
        state_d = RUN;
      end else begin
        {ph, fif} = '1;
        state_d   = (cnt_q == LAST) ? INJECT : DRAIN;
        cnt_d     = (cnt_q == LAST) ? cnt_q : cnt_q + 3'd1;
      end
    end else if (state_q == INJECT) begin
      {sc, ack} = '1;
      state_d   = RUN;
    end else begin
      state_d = RUN;
    end
    ack_d = ack;
    if (!rst) {ph, sif, sie, sem, fif, fie, bub, sc, ack} = '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end
  assign bus.pc_hold       = ph;
  assign bus.stall_if_id   = sif;
  assign bus.stall_id_ex   = sie;
  assign bus.stall_ex_mem  = sem;
  assign bus.flush_if_id   = fif;
  assign bus.flush_id_ex   = fie;
  assign bus.ex_mem_bubble = bub;
  assign bus.store_current = sc;
  assign bus.irq_ack       = ack;
  assign state_o           = rst ? state_q : RUN;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(ph & ~&stall_cnt_q);
    flush_cnt_d = flush_cnt_q + CNT_W'(fie & ~&flush_cnt_q);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign stall_cnt = rst ? stall_cnt_q : '0;
  assign flush_cnt = rst ? flush_cnt_q : '0;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl with DRAIN_CYCLES=2.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  pipe_hazard_ctrl_if bus();
  logic [1:0]  state_o;
  logic [15:0] stall_cnt, flush_cnt;
  pipe_hazard_ctrl #(.DRAIN_CYCLES(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_o   (state_o),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
  typedef struct {
    string       tag;
    logic [10:0] exp;
    bit          zc;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  // expected vector: pc_hold stall_if_id stall_id_ex stall_ex_mem flush_if_id flush_id_ex bubble store_current irq_ack state
  function automatic logic [10:0] e(input bit ph, sif, sie, sem, fif, fie, bub, sc, ack, input logic [1:0] st);
    return {ph, sif, sie, sem, fif, fie, bub, sc, ack, st};
  endfunction
  task automatic step(input string tag, input logic r, mb, snd, txf, br, irq, mre, we,
                      input logic [3:0] dst, p0, input logic u0, input logic [3:0] p1, input logic u1,
                      input logic [10:0] exp, input bit zc);
    @(posedge clk);
    #1;
    rst              = r;
    bus.mem_busy     = mb;
    bus.ex_send      = snd;
    bus.tx_full      = txf;
    bus.branch_taken = br;
    bus.irq_req      = irq;
    bus.ex_mem_re    = mre;
    bus.ex_we        = we;
    bus.ex_dst_addr  = dst;
    bus.id_p0_addr   = p0;
    bus.id_p0_used   = u0;
    bus.id_p1_addr   = p1;
    bus.id_p1_used   = u1;
    q.push_back('{tag, exp, zc});
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      check(x.tag, 32'({bus.pc_hold, bus.stall_if_id, bus.stall_id_ex, bus.stall_ex_mem, bus.flush_if_id,
                        bus.flush_id_ex, bus.ex_mem_bubble, bus.store_current, bus.irq_ack, state_o}), 32'(x.exp));
      if (!PERF || x.zc) begin
        check({x.tag, "_scnt"}, 32'(stall_cnt), 32'd0);
        check({x.tag, "_fcnt"}, 32'(flush_cnt), 32'd0);
      end
    end
  end
  initial begin
    logic [10:0] z, lu, tx, inj;
    z   = e(0,0,0,0,0,0,0,0,0,2'd0);
    lu  = e(1,1,0,0,0,1,0,0,0,2'd0);
    tx  = e(1,1,1,0,0,0,1,0,0,2'd0);
    inj = e(0,0,0,0,0,0,0,1,1,2'd2);
    {bus.mem_busy, bus.ex_send, bus.tx_full, bus.branch_taken, bus.irq_req, bus.ex_mem_re, bus.ex_we} = '0;
    {bus.ex_dst_addr, bus.id_p0_addr, bus.id_p1_addr, bus.id_p0_used, bus.id_p1_used} = '0;
    step("rst_hold",  0, 1,1,1,1,1, 1,1, 4'd3, 4'd3,1, 4'd3,1, z, 1);
    step("rst_rel",   1, 0,0,0,0,0, 0,0, 4'd0, 4'd0,0, 4'd0,0, z, 1);
    step("lu_r3_p1",  1, 0,0,0,0,0, 1,1, 4'd3, 4'd0,0, 4'd3,1, lu, 0);
    step("lu_after",  1, 0,0,0,0,0, 0,0, 4'd0, 4'd0,0, 4'd3,1, z, 0);
    step("lu_r0",     1, 0,0,0,0,0, 1,1, 4'd0, 4'd0,1, 4'd0,1, z, 0);
    step("lu_unused", 1, 0,0,0,0,0, 1,1, 4'd5, 4'd5,0, 4'd2,1, z, 0);
    for (int i = 0; i < 3; i++)
      step($sformatf("mb_lu%0d", i), 1, 1,0,0,0,0, 1,1, 4'd3, 4'd3,1, 4'd0,0, e(1,1,1,1,0,0,0,0,0,2'd0), 0);
    step("lu_after_mb", 1, 0,0,0,0,0, 1,1, 4'd3, 4'd3,1, 4'd0,0, lu, 0);
    for (int i = 0; i < 5; i++)
      step($sformatf("tx_wait%0d", i), 1, 0,1,1,0,0, 0,0, 4'd0, 4'd0,0, 4'd0,0, tx, 0);
    step("tx_release", 1, 0,1,0,0,0, 0,0, 4'd0, 4'd0,0, 4'd0,0, z, 0);
    step("tx_over_br", 1, 0,1,1,1,0, 0,0, 4'd0, 4'd0,0, 4'd0,0, tx, 0);
    step("br_over_lu", 1, 0,0,0,1,0, 1,1, 4'd3, 4'd3,1, 4'd0,0, e(0,0,0,0,1,1,0,0,0,2'd0), 0);
    step("irq_accept", 1, 0,0,0,0,1, 0,0, 4'd0, 4'd0,0, 4'd0,0, e(1,0,0,0,1,0,0,0,0,2'd0), 0);
    step("drain0",     1, 0,0,0,0,1, 0,0, 4'd0, 4'd0,0, 4'd0,0, e(1,0,0,0,1,0,0,0,0,2'd1), 0);
    step("drain1",     1, 0,0,0,0,1, 0,0, 4'd0, 4'd0,0, 4'd0,0, e(1,0,0,0,1,0,0,0,0,2'd1), 0);
    step("inject",     1, 0,0,0,0,1, 0,0, 4'd0, 4'd0,0, 4'd0,0, inj, 0);
    step("no_reaccept",1, 0,0,0,0,1, 0,0, 4'd0, 4'd0,0, 4'd0,0, z, 0);
    step("irq2_accept",1, 0,0,0,0,1, 0,0, 4'd0, 4'd0,0, 4'd0,0, e(1,0,0,0,1,0,0,0,0,2'd0), 0);
    step("drain_br",   1, 0,0,0,1,1, 0,0, 4'd0, 4'd0,0, 4'd0,0, e(0,0,0,0,1,1,0,0,0,2'd1), 0);
    step("redrain0",   1, 0,0,0,0,1, 0,0, 4'd0, 4'd0,0, 4'd0,0, e(1,0,0,0,1,0,0,0,0,2'd1), 0);
    step("redrain1",   1, 0,0,0,0,1, 0,0, 4'd0, 4'd0,0, 4'd0,0, e(1,0,0,0,1,0,0,0,0,2'd1), 0);
    step("inject_mb",  1, 1,0,0,0,1, 0,0, 4'd0, 4'd0,0, 4'd0,0, e(1,1,1,1,0,0,0,0,0,2'd2), 0);
    step("inject2",    1, 0,0,0,0,1, 0,0, 4'd0, 4'd0,0, 4'd0,0, inj, 0);
    step("irq_low",    1, 0,0,0,0,0, 0,0, 4'd0, 4'd0,0, 4'd0,0, z, 0);
    step("irq3_accept",1, 0,0,0,0,1, 0,0, 4'd0, 4'd0,0, 4'd0,0, e(1,0,0,0,1,0,0,0,0,2'd0), 0);
    step("drain_drop", 1, 0,0,0,0,0, 0,0, 4'd0, 4'd0,0, 4'd0,0, e(0,0,0,0,0,0,0,0,0,2'd1), 0);
    step("drop_run",   1, 0,0,0,0,0, 0,0, 4'd0, 4'd0,0, 4'd0,0, z, 0);
    step("irq4_accept",1, 0,0,0,0,1, 0,0, 4'd0, 4'd0,0, 4'd0,0, e(1,0,0,0,1,0,0,0,0,2'd0), 0);
    step("drain_rst",  0, 0,0,0,0,1, 0,0, 4'd0, 4'd0,0, 4'd0,0, z, 1);
    step("after_rst",  1, 0,0,0,0,0, 0,0, 4'd0, 4'd0,0, 4'd0,0, z, 1);
    @(negedge clk);
    #1;
    check("sb_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage processor pipeline.
- Generates every stall, flush and store_current control for the IF/ID, ID/EX and EX/MEM pipeline registers, plus the PC hold.
- Resolves load-use hazards, taken-branch flushes, data-memory wait and SPART transmit back-pressure.
- Injects interrupts by draining the pipe and forcing one store_current cycle, which saves the return PC to R15.

Parameters:
DRAIN_CYCLES, 2, number of cycles fetch is held before interrupt injection (1..7)
CNT_W, 16, width of the optional performance counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk
ex_mem_re  in  1  ID/EX stage holds a load
ex_we  in  1  ID/EX stage writes the register file
ex_dst_addr  in  4  ID/EX destination register
id_p0_addr  in  4  decode source register 0
id_p1_addr  in  4  decode source register 1
id_p0_used  in  1  decode reads p0
id_p1_used  in  1  decode reads p1
branch_taken  in  1  branch resolved taken in EX this cycle
mem_busy  in  1  data memory not ready
ex_send  in  1  ID/EX holds a SPART send
tx_full  in  1  SPART transmit buffer full
irq_req  in  1  level interrupt request
pc_hold  out  1  PC register holds
stall_if_id  out  1  to IF/ID stall
stall_id_ex  out  1  to ID/EX stall
stall_ex_mem  out  1  to EX/MEM stall
flush_if_id  out  1  top inserts a NOP into IF/ID
flush_id_ex  out  1  to ID/EX flush
ex_mem_bubble  out  1  top zeroes EX/MEM we, Mem_re and Mem_we inputs
store_current  out  1  to ID/EX store_current
irq_ack  out  1  one-cycle interrupt accept pulse
state_o  out  2  current FSM state, for debug
stall_cnt  out  CNT_W  stall cycles (optional feature)
flush_cnt  out  CNT_W  flush events (optional feature)

Behaviour:
- Reset: while rst==0 at a clock edge, state<=RUN and drain counter<=0. While rst==0, all outputs are forced to 0 combinationally, including state_o=RUN. Reset mid-drain or mid-injection aborts the operation and raises no irq_ack.
- Outputs are combinational from the registered state and current inputs; zero-cycle reaction. State updates on the clk rising edge.
- load_use = ex_mem_re & ex_we & (ex_dst_addr!=0) & ((id_p0_used & id_p0_addr==ex_dst_addr) | (id_p1_used & id_p1_addr==ex_dst_addr)). R0 is hardwired zero and never causes a hazard.
- Priority per cycle, highest first: mem_busy > tx_wait (ex_send & tx_full) > branch_taken > load_use > irq.
- mem_busy: pc_hold, stall_if_id, stall_id_ex and stall_ex_mem all =1. No flush outputs assert. The FSM state and drain counter freeze.
- tx_wait: pc_hold, stall_if_id and stall_id_ex =1; ex_mem_bubble=1; stall_ex_mem=0. Releases the same cycle tx_full falls.
- branch_taken: flush_if_id=1 and flush_id_ex=1 for one cycle; the PC is loaded by the branch unit. The cycle's load_use is ignored because the consumer is flushed.
- load_use: pc_hold=1, stall_if_id=1, flush_id_ex=1 for exactly one cycle. The next cycle re-evaluates with the load now in EX/MEM.
- FSM states: RUN(0), DRAIN(1), INJECT(2).
  - RUN: irq_req=1 with no higher-priority event -> DRAIN, counter<=0. pc_hold=1 and flush_if_id=1 from the DRAIN entry onward.
  - DRAIN: pc_hold=1 and flush_if_id=1 each cycle; counter increments. When counter==DRAIN_CYCLES-1 -> INJECT. branch_taken in DRAIN flushes as normal and restarts the counter at 0, so the saved PC is the branch target. irq_req dropping in DRAIN -> RUN with no ack.
  - INJECT: store_current=1, irq_ack=1, pc_hold=0 for exactly one cycle, then -> RUN. mem_busy in INJECT holds the state, with store_current=0 and irq_ack=0 until it clears.
- irq is not re-accepted in the cycle immediately after irq_ack.

Optional Feature:
- PIPE_PERF_CNT_EN defined:
  - stall_cnt increments in every cycle where pc_hold=1.
  - flush_cnt increments in every cycle where flush_id_ex=1.
  - Both counters saturate at all-ones and clear on reset.
- PIPE_PERF_CNT_EN undefined: stall_cnt and flush_cnt are tied to 0 and no counter registers exist.

Decomposition:
- Shared package pipe_ctrl_pkg holds the state encodings RUN/DRAIN/INJECT, the R0 address constant and REG_LINK=4'hF.
- One natural sub-module: hazard_detect, purely combinational, computing load_use and tx_wait.

Test Plan:
- Load to R3 in ID/EX, decode reads R3 on p1 -> one cycle of pc_hold=1, stall_if_id=1, flush_id_ex=1, then all 0.
- Load to R0, decode reads R0 -> no stall.
- mem_busy held 3 cycles while a load_use is also present -> all four stalls =1 for 3 cycles, no flush; load_use bubble in the 4th cycle.
- ex_send=1, tx_full=1 for 5 cycles -> stall_id_ex=1 and ex_mem_bubble=1 for 5 cycles, release the cycle tx_full=0.
- irq_req=1 in RUN with DRAIN_CYCLES=2 -> DRAIN 2 cycles, then INJECT 1 cycle (store_current=1, irq_ack=1), then RUN. branch_taken in DRAIN cycle 1 -> drain restarts and irq_ack is delayed by 1 cycle.
- rst=0 asserted during DRAIN -> next cycle state_o=0, no irq_ack; with PIPE_PERF_CNT_EN both counters read 0.
